// File: rtl/operand_mux_reg.sv
// Registered N-way operand selector with valid/ready handshaking.
// Chooses a source by direct select or round-robin and holds the last captured word.
module operand_mux_reg #(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    mode,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_src,
    output logic                    sel_err
);

    localparam logic [SEL_W-1:0] LP_LAST = SEL_W'(NUM_IN - 1);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic [SEL_W-1:0] r_src;
    logic [SEL_W-1:0] r_rr_ptr;
    logic             r_sel_err;

    logic             w_load_en;
    logic             w_sel_in_range;
    logic             w_sel_valid;
    logic             w_rr_found;
    logic [SEL_W-1:0] w_rr_idx;
    logic             w_grant;
    logic [SEL_W-1:0] w_gnt_idx;
    logic [WIDTH-1:0] w_gnt_data;
    logic             w_err;

    assign w_load_en      = !r_valid || out_ready;
    assign w_sel_in_range = (int'(sel) < NUM_IN);

    always_comb begin
        w_sel_valid = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (int'(sel) == i) begin
                w_sel_valid = in_valid[i];
            end
        end
    end

    // Search begins one past the last granted channel, wrapping modulo NUM_IN.
    always_comb begin
        int v_idx;
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        v_idx      = 0;
        for (int k = 1; k <= NUM_IN; k++) begin
            v_idx = (int'(r_rr_ptr) + k) % NUM_IN;
            for (int j = 0; j < NUM_IN; j++) begin
                if (!w_rr_found && (j == v_idx) && in_valid[j]) begin
                    w_rr_found = 1'b1;
                    w_rr_idx   = SEL_W'(j);
                end
            end
        end
    end

    always_comb begin
        w_grant   = 1'b0;
        w_gnt_idx = '0;
        w_err     = 1'b0;
        if (rst_n && w_load_en) begin
            if (!mode) begin
                if (!w_sel_in_range) begin
                    w_err = 1'b1;
                end else if (w_sel_valid) begin
                    w_grant   = 1'b1;
                    w_gnt_idx = sel;
                end
            end else if (w_rr_found) begin
                w_grant   = 1'b1;
                w_gnt_idx = w_rr_idx;
            end
        end
    end

    always_comb begin
        in_ready   = '0;
        w_gnt_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_grant && (int'(w_gnt_idx) == i)) begin
                in_ready[i] = 1'b1;
                w_gnt_data  = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_src     <= '0;
            r_rr_ptr  <= LP_LAST;
            r_sel_err <= 1'b0;
        end else begin
            r_sel_err <= w_err;
            if (w_grant) begin
                r_data  <= w_gnt_data;
                r_src   <= w_gnt_idx;
                r_valid <= 1'b1;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
            // Pointer only moves on round-robin grants; direct grants leave it alone.
            if (w_grant && mode) begin
                r_rr_ptr <= w_gnt_idx;
            end
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign out_src   = r_src;
    assign sel_err   = r_sel_err;

endmodule

// File: doc/operand_mux_reg.md
# operand_mux_reg

Parametrised, registered N-way operand selector with valid/ready handshaking. It is the successor to the datapath's combinational 3:1 select mux. It adds configurable width and input count, a registered output that holds cleanly when nothing is selected, a round-robin mode for sharing one bus among several producers, and a select-range error flag. It sits between the register file / forwarding sources and the ALU operand and writeback buses.

## Interface
Parameters:
- WIDTH, 16, data width of each input and of the output
- NUM_IN, 4, number of input channels (2..16)
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_data  input  NUM_IN*WIDTH  packed inputs; channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  NUM_IN  per-channel data valid
- in_ready  output  NUM_IN  per-channel accept; combinational, at most one bit high
- sel  input  SEL_W  channel select, used in mode 0
- mode  input  1  0 = direct select, 1 = round-robin among valid channels
- out_data  output  WIDTH  registered selected data
- out_valid  output  1  out_data holds an unconsumed word
- out_ready  input  1  consumer accepts out_data this cycle
- out_src  output  SEL_W  index of the channel that supplied out_data
- sel_err  output  1  one-cycle pulse: out-of-range select was presented

## Operation
- load_en = !out_valid || out_ready. The output register is free, or is being drained this cycle.
- Mode 0 (direct):
  - Candidate is channel sel.
  - Grant only if sel < NUM_IN, in_valid[sel] = 1 and load_en = 1.
- Mode 1 (round-robin):
  - Search channels starting at rr_ptr+1, wrapping modulo NUM_IN.
  - The first channel with in_valid = 1 is granted if load_en = 1.
  - rr_ptr updates to the granted index on a grant only; otherwise it is unchanged.
  - sel is ignored.
- Grant to channel g:
  - in_ready[g] = 1 in the same cycle.
  - At the next edge: out_data <= channel g data, out_src <= g, out_valid <= 1.
- No grant and out_ready = 1 with out_valid = 1: out_valid <= 0.
- out_data and out_src are never cleared by draining. They hold the last captured word. This replaces the old latch-style "out = out" default with a real register.
- in_ready is all-zero whenever load_en = 0. In mode 0 it is also all-zero when sel is out of range or the selected channel is not valid.
- sel_err:
  - Registered. Set for exactly one cycle after any cycle with mode = 0, load_en = 1 and sel >= NUM_IN.
  - No capture occurs in that cycle; out_valid follows the drain rule.
  - sel_err is never asserted in mode 1.
- Mode may change on any cycle. It takes effect combinationally for that cycle's grant. rr_ptr is retained across mode switches and updates only on mode-1 grants.

## Timing
- Reset (rst_n low, asynchronous, any time) forces:
  - out_data = 0, out_valid = 0, out_src = 0, sel_err = 0
  - rr_ptr = NUM_IN-1, so the first round-robin search starts at channel 0
- Reset mid-transfer discards the held word; no in_ready is asserted while rst_n is low.
- Latency: input accepted in cycle n appears on out_data/out_valid in cycle n+1.
- Throughput: one word per cycle while out_ready is held high and a candidate exists.
- Backpressure: out_valid = 1 with out_ready = 0 holds out_data, out_src and out_valid stable, and drops all in_ready.
- Simultaneous drain and load (out_valid = 1, out_ready = 1, grant): the new word replaces the old one, and out_valid stays 1.
- Round-robin wrap: with rr_ptr = NUM_IN-1 the search order is 0, 1, …, NUM_IN-1.

## Test plan
- Reset: assert rst_n = 0 mid-stream with out_valid = 1 -> out_data = 0x0000, out_valid = 0, out_src = 0, sel_err = 0 immediately. After release, the first mode-1 grant goes to channel 0.
- Direct select: mode = 0, sel = 2, in_valid = 4'b0100, ch2 = 0xBEEF, out_ready = 1 -> in_ready = 4'b0100. Next cycle out_data = 0xBEEF, out_src = 2, out_valid = 1.
- Backpressure: out_valid = 1 holding 0x1234, out_ready = 0 for 3 cycles with all in_valid = 1 -> in_ready = 0 throughout; out_data stays 0x1234. Raising out_ready gives a new capture the next cycle with no gap.
- Round-robin fairness: mode = 1, all four channels valid (0x000A/0x000B/0x000C/0x000D), out_ready = 1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3 with matching data. With only channels 1 and 3 valid -> sequence 1,3,1,3.
- Out-of-range select: NUM_IN = 3, SEL_W = 2, mode = 0, sel = 3, out_valid = 0 -> no in_ready. sel_err = 1 for one cycle; out_data keeps its previous value; out_valid stays 0.
- Invalid selected channel: mode = 0, sel = 1, in_valid[1] = 0, out_valid = 1, out_ready = 1 -> out_valid drops to 0 next cycle, out_data is held, sel_err = 0.
